// File: rtl/matmul_rect_top.sv
// -----------------------------------------------------------------------------
// matmul_rect_top
//
// Rectangular signed matrix-multiply engine. It computes C = A x B, or
// C = C + A x B when accum is set with start. A is M_DIM x K_DIM, B is
// K_DIM x N_DIM and C is M_DIM x N_DIM. All three matrices are stored
// row-major in internal single-write-port BRAMs that have a 1-cycle
// registered read.
//
// Sequencing, per output element (i, j), takes K_DIM + 2 cycles:
//   ISSUE  K_DIM cycles  A/B read addresses for k = 0..K_DIM-1. On k = 0 the
//                        old C(i, j) is also read for accumulate mode.
//   DRAIN  1 cycle       adds the last product and, if accum is set, old C.
//   WRITE  1 cycle       stores the result to C(i, j), then advances j and i.
// After the last element the FSM goes to DONE, which pulses done for one
// cycle, and then returns to IDLE.
//
// While busy, host writes to A and B are ignored, start is ignored, and the
// C read port is driven by the sequencer.
//
// Compile-time option:
//   MATMUL_SAT_EN  when defined, the result is clamped to the signed
//                  DATA_WIDTH range before it is written. Otherwise the low
//                  DATA_WIDTH bits are stored (two's-complement wrap).
//                  Timing is identical in both builds.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-low
//   start      in   one-cycle request, sampled only in IDLE
//   accum      in   sampled with start; 1 selects C = C + A x B
//   busy       out  high while a computation is in progress
//   done       out  one-cycle pulse after the final C write
//   a_wr_*     in   host write port for A, address i*K_DIM + k
//   b_wr_*     in   host write port for B, address k*N_DIM + j
//   c_rd_addr  in   host read address for C, address i*N_DIM + j
//   c_rd_dout  out  C read data, valid 1 cycle after c_rd_addr
// -----------------------------------------------------------------------------
module matmul_rect_top #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int M_DIM      = 8,
  parameter int K_DIM      = 8,
  parameter int N_DIM      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accum,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] a_wr_din,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic                  a_wr_en,
  input  logic [DATA_WIDTH-1:0] b_wr_din,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic                  b_wr_en,
  input  logic [ADDR_WIDTH-1:0] c_rd_addr,
  output logic [DATA_WIDTH-1:0] c_rd_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int IW    = (M_DIM > 1) ? $clog2(M_DIM) : 1;
  localparam int JW    = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam int KW    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  // Wide enough for K_DIM full products plus the old C value.
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(K_DIM) + 1;

  // Elaboration-time geometry checks.
  if (K_DIM < 1) begin : g_chk_k
    $error("matmul_rect_top: K_DIM must be at least 1");
  end
  if (M_DIM * K_DIM > DEPTH) begin : g_chk_a
    $error("matmul_rect_top: M_DIM*K_DIM exceeds A BRAM depth");
  end
  if (K_DIM * N_DIM > DEPTH) begin : g_chk_b
    $error("matmul_rect_top: K_DIM*N_DIM exceeds B BRAM depth");
  end
  if (M_DIM * N_DIM > DEPTH) begin : g_chk_c
    $error("matmul_rect_top: M_DIM*N_DIM exceeds C BRAM depth");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [IW-1:0]            i_q;
  logic [JW-1:0]            j_q;
  logic [KW-1:0]            k_q;
  logic                     accum_q;
  logic                     busy_q;
  logic                     done_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // BRAM storage and registered read outputs.
  logic [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];
  logic [DATA_WIDTH-1:0] c_mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_dout_q;
  logic [DATA_WIDTH-1:0] b_dout_q;
  logic [DATA_WIDTH-1:0] c_dout_q;

  // Sequencer-generated addresses.
  logic [ADDR_WIDTH-1:0] a_rd_addr;
  logic [ADDR_WIDTH-1:0] b_rd_addr;
  logic [ADDR_WIDTH-1:0] c_seq_addr;
  logic [ADDR_WIDTH-1:0] c_rd_mux;
  logic                  a_we;
  logic                  b_we;
  logic                  c_we;
  logic [DATA_WIDTH-1:0] c_wdata;

  assign a_rd_addr  = ADDR_WIDTH'(i_q) * ADDR_WIDTH'(K_DIM) + ADDR_WIDTH'(k_q);
  assign b_rd_addr  = ADDR_WIDTH'(j_q) + ADDR_WIDTH'(k_q) * ADDR_WIDTH'(N_DIM);
  // The C address is held for the whole element, so the old C value read on
  // k = 0 is still sitting in the read register when DRAIN uses it.
  assign c_seq_addr = ADDR_WIDTH'(i_q) * ADDR_WIDTH'(N_DIM) + ADDR_WIDTH'(j_q);
  assign c_rd_mux   = busy_q ? c_seq_addr : c_rd_addr;

  // A start in IDLE does not block a same-cycle write: busy_q is still low.
  assign a_we = a_wr_en & ~busy_q;
  assign b_we = b_wr_en & ~busy_q;
  assign c_we = (state_q == S_WRITE);

  // ---------------------------------------------------------------------------
  // BRAMs
  // ---------------------------------------------------------------------------
  // NOTE: memory arrays and their read registers carry no reset, so they map
  // onto block RAM; contents survive a reset.
  always_ff @(posedge clock) begin
    if (a_we) a_mem[a_wr_addr] <= a_wr_din;
    a_dout_q <= a_mem[a_rd_addr];
  end

  always_ff @(posedge clock) begin
    if (b_we) b_mem[b_wr_addr] <= b_wr_din;
    b_dout_q <= b_mem[b_rd_addr];
  end

  always_ff @(posedge clock) begin
    if (c_we) c_mem[c_seq_addr] <= c_wdata;
    c_dout_q <= c_mem[c_rd_mux];
  end

  assign c_rd_dout = c_dout_q;

  // ---------------------------------------------------------------------------
  // Multiply-accumulate datapath
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] c_old;

  // Sign-extend both operands to the accumulator width; the product of two
  // DATA_WIDTH values fits in 2*DATA_WIDTH bits, so nothing is lost.
  assign prod  = ACC_W'($signed(a_dout_q)) * ACC_W'($signed(b_dout_q));
  assign c_old = ACC_W'($signed(c_dout_q));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_d = acc_q;
    unique case (state_q)
      // Data for address k arrives one cycle later, so k = 0 has nothing yet.
      S_ISSUE: if (k_q != '0) acc_d = acc_q + prod;
      S_DRAIN: acc_d = acc_q + prod + (accum_q ? c_old : '0);
      // IDLE and WRITE are the only states that lead into ISSUE; clearing
      // here gives a zero accumulator on every ISSUE entry.
      S_IDLE, S_WRITE: acc_d = '0;
      default: acc_d = acc_q;
    endcase
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    c_wdata = acc_q[DATA_WIDTH-1:0];
    if (acc_q > SAT_MAX) begin
      c_wdata = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc_q < SAT_MIN) begin
      c_wdata = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  assign c_wdata = acc_q[DATA_WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered busy/done
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      accum_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            accum_q <= accum;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (k_q == KW'(K_DIM - 1)) begin
            k_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DRAIN: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (j_q == JW'(N_DIM - 1)) begin
            j_q <= '0;
            if (i_q == IW'(M_DIM - 1)) begin
              i_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              i_q     <= i_q + IW'(1);
              state_q <= S_ISSUE;
            end
          end else begin
            j_q     <= j_q + JW'(1);
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
